// File: rtl/usb_cdc_arb_pkg.sv
// Shared definitions for the usb_cdc IN-stream arbiter: FSM encodings, tag nibble
// and the round-robin pick helper.
package usb_cdc_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    localparam logic [3:0] TAG_NIBBLE = 4'hA;

    // First set bit of valid at or after ptr, wrapping modulo num; returned one-hot.
    function automatic logic [15:0] rr_pick(input logic [15:0] valid,
                                            input logic [3:0]  ptr,
                                            input logic [4:0]  num);
        logic [15:0] pick;
        logic        found;
        logic [4:0]  sum;
        logic [4:0]  idx;
        pick  = 16'h0000;
        found = 1'b0;
        for (int k = 0; k < 16; k++) begin
            sum = {1'b0, ptr} + 5'(k);
            idx = (sum >= num) ? (sum - num) : sum;
            if (!found && (5'(k) < num) && valid[idx[3:0]]) begin
                pick[idx[3:0]] = 1'b1;
                found          = 1'b1;
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/usb_cdc_in_arbiter_rr_picker.sv
// Combinational rotating-priority picker: one-hot winner plus its encoded index.
// Generic over NUM_REQ so other usb_cdc arbiters can reuse it.
module usb_cdc_rr_picker
    import usb_cdc_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [3:0]         ptr_i,
    output logic               any_o,
    output logic [NUM_REQ-1:0] onehot_o,
    output logic [3:0]         idx_o
);

    logic [15:0] valid_ext_s;
    logic [15:0] pick_s;

    // Widen to the helper's fixed width, pick, then encode the winner.
    always_comb begin
        valid_ext_s                = 16'h0000;
        valid_ext_s[NUM_REQ-1:0]   = valid_i;
        pick_s                     = rr_pick(valid_ext_s, ptr_i, 5'(NUM_REQ));
        onehot_o                   = pick_s[NUM_REQ-1:0];
        any_o                      = |valid_i;
        idx_o                      = 4'd0;
        for (int i = 0; i < 16; i++) begin
            idx_o = idx_o | (pick_s[i] ? 4'(i) : 4'd0);
        end
    end

endmodule

// File: rtl/usb_cdc_in_arbiter.sv
// Burst-granular round-robin arbiter feeding the usb_cdc IN byte stream through one
// registered stage. Define USB_CDC_ARB_TAG_EN to prefix each burst with {A, owner}.
module usb_cdc_in_arbiter
    import usb_cdc_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 8
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 configured_i,
    input  logic [8*NUM_REQ-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [NUM_REQ-1:0]   req_last_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic [7:0]           in_data_o,
    output logic                 in_valid_o,
    input  logic                 in_ready_i
);

    logic [1:0]         state_q, state_d;
    logic [3:0]         rr_ptr_q, rr_ptr_d;
    logic [7:0]         burst_cnt_q, burst_cnt_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [3:0]         gidx_q, gidx_d;
    logic [7:0]         data_q, data_d;
    logic               valid_q, valid_d;
    logic               abort_q, abort_d;

    logic               pick_any_s;
    logic [NUM_REQ-1:0] pick_onehot_s;
    logic [3:0]         pick_idx_s;
    logic               free_s;
    logic               owner_valid_s;
    logic               owner_last_s;
    logic [7:0]         owner_data_s;
    logic               accept_s;
    logic               burst_done_s;
    logic [3:0]         next_ptr_s;

    usb_cdc_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .valid_i  (req_valid_i),
        .ptr_i    (rr_ptr_q),
        .any_o    (pick_any_s),
        .onehot_o (pick_onehot_s),
        .idx_o    (pick_idx_s)
    );

    // Owner's stream selected by the one-hot grant; burst-end and pointer-advance terms.
    always_comb begin
        free_s        = ~valid_q | in_ready_i;
        owner_valid_s = |(req_valid_i & grant_q);
        owner_last_s  = |(req_last_i & grant_q);
        owner_data_s  = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            owner_data_s = owner_data_s | (req_data_i[8*i +: 8] & {8{grant_q[i]}});
        end
        accept_s     = (state_q == ST_DATA) & configured_i & free_s & owner_valid_s;
        burst_done_s = owner_last_s | (({1'b0, burst_cnt_q} + 9'd1) == 9'(MAX_BURST));
        next_ptr_s   = (gidx_q == 4'(NUM_REQ - 1)) ? 4'd0 : (gidx_q + 4'd1);
    end

    // Only the owner sees ready, and only while the output stage can take a byte.
    always_comb begin
        if ((state_q == ST_DATA) && configured_i && free_s) begin
            req_ready_o = grant_q;
        end else begin
            req_ready_o = '0;
        end
    end

    // Arbitration FSM, burst counter and output register next-state.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        grant_d     = grant_q;
        gidx_d      = gidx_q;
        data_d      = data_q;
        valid_d     = valid_q;
        abort_d     = 1'b0;

        if (valid_q && in_ready_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        // A byte still pending one cycle after an abort is discarded.
        if (abort_q) begin
            valid_d = 1'b0;
        end else begin
            abort_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (configured_i && pick_any_s) begin
                    grant_d     = pick_onehot_s;
                    gidx_d      = pick_idx_s;
                    burst_cnt_d = 8'd0;
`ifdef USB_CDC_ARB_TAG_EN
                    state_d     = ST_HDR;
`else
                    state_d     = ST_DATA;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
`ifdef USB_CDC_ARB_TAG_EN
            ST_HDR: begin
                if (!configured_i) begin
                    state_d  = ST_IDLE;
                    grant_d  = '0;
                    rr_ptr_d = next_ptr_s;
                    abort_d  = 1'b1;
                end else if (free_s) begin
                    data_d  = {TAG_NIBBLE, gidx_q};
                    valid_d = 1'b1;
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_HDR;
                end
            end
`endif
            ST_DATA: begin
                if (!configured_i) begin
                    state_d  = ST_IDLE;
                    grant_d  = '0;
                    rr_ptr_d = next_ptr_s;
                    abort_d  = 1'b1;
                end else if (accept_s) begin
                    data_d      = owner_data_s;
                    valid_d     = 1'b1;
                    burst_cnt_d = burst_cnt_q + 8'd1;
                    if (burst_done_s) begin
                        state_d  = ST_IDLE;
                        grant_d  = '0;
                        rr_ptr_d = next_ptr_s;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= 4'd0;
            burst_cnt_q <= 8'd0;
            grant_q     <= '0;
            gidx_q      <= 4'd0;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            grant_q     <= grant_d;
            gidx_q      <= gidx_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            abort_q     <= abort_d;
        end
    end

    assign grant_o    = grant_q;
    assign in_data_o  = data_q;
    assign in_valid_o = valid_q;

endmodule

// File: tb/tb_usb_cdc_in_arbiter.sv
// Bench for usb_cdc_in_arbiter: directed timing scenarios plus randomized streams checked
// against a round-robin stream model built from per-requester byte queues.
module tb_usb_cdc_in_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int MAX_BURST = 8;
`ifdef USB_CDC_ARB_TAG_EN
    localparam int HL  = 1;
    localparam bit TAG = 1'b1;
`else
    localparam int HL  = 0;
    localparam bit TAG = 1'b0;
`endif

    logic                 clk;
    logic                 rstn;
    logic                 configured;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   grant;
    logic [7:0]           in_data;
    logic                 in_valid;
    logic                 in_ready;

    int vectors     = 0;
    int miscompares = 0;
    int model_ptr   = 0;

    logic [8:0] rq [NUM_REQ][$];
    logic [7:0] exp_q[$];
    logic [7:0] out_log[$];
    logic       log_valid[$];
    logic [7:0] log_data[$];
    logic [3:0] log_grant[$];

    usb_cdc_in_arbiter #(.NUM_REQ(NUM_REQ), .MAX_BURST(MAX_BURST)) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .configured_i (configured),
        .req_data_i   (req_data),
        .req_valid_i  (req_valid),
        .req_last_i   (req_last),
        .req_ready_o  (req_ready),
        .grant_o      (grant),
        .in_data_o    (in_data),
        .in_valid_o   (in_valid),
        .in_ready_i   (in_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_reqs();
        for (int n = 0; n < NUM_REQ; n++) begin
            if (rq[n].size() > 0) begin
                req_valid[n]        = 1'b1;
                req_last[n]         = rq[n][0][8];
                req_data[8*n +: 8]  = rq[n][0][7:0];
            end else begin
                req_valid[n]        = 1'b0;
                req_last[n]         = 1'b0;
                req_data[8*n +: 8]  = 8'h00;
            end
        end
    endtask

    // Expected byte stream: round robin over non-empty queues, bursts end on last or MAX_BURST.
    task automatic model_stream();
        logic [8:0] cq [NUM_REQ][$];
        logic [8:0] e;
        int ptr, g, cnt;
        bit done;
        for (int n = 0; n < NUM_REQ; n++) cq[n] = rq[n];
        ptr = model_ptr;
        exp_q.delete();
        while (1) begin
            g = -1;
            for (int k = 0; k < NUM_REQ; k++)
                if (g < 0 && cq[(ptr + k) % NUM_REQ].size() > 0) g = (ptr + k) % NUM_REQ;
            if (g < 0) break;
            if (TAG) exp_q.push_back({4'hA, 4'(g)});
            cnt  = 0;
            done = 1'b0;
            while (!done) begin
                e = cq[g].pop_front();
                exp_q.push_back(e[7:0]);
                cnt++;
                done = e[8] || (cnt == MAX_BURST) || (cq[g].size() == 0);
            end
            ptr = (g + 1) % NUM_REQ;
        end
        model_ptr = ptr;
    endtask

    // Runs the loaded queues through the DUT; mode 0 ready=1, 1 toggling, 2 random.
    task automatic run_engine(input int ready_mode, input int max_cyc);
        logic [NUM_REQ-1:0] acc;
        logic               prev_stall;
        logic [7:0]         prev_data;
        logic               tog;
        int                 cyc;
        model_stream();
        out_log.delete(); log_valid.delete(); log_data.delete(); log_grant.delete();
        prev_stall = 1'b0; prev_data = 8'h00; tog = 1'b1; cyc = 0;
        while (exp_q.size() > 0 && cyc < max_cyc) begin
            drive_reqs();
            case (ready_mode)
                0:       in_ready = 1'b1;
                1:       begin in_ready = tog; tog = ~tog; end
                default: in_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            log_valid.push_back(in_valid);
            log_data.push_back(in_data);
            log_grant.push_back(4'(grant));
            if (prev_stall) begin
                vectors++;
                if (in_valid !== 1'b1 || in_data !== prev_data) begin
                    miscompares++;
                    $display("FAIL hold_stable: got valid=%0b data=%02h, expected valid=1 data=%02h",
                             in_valid, in_data, prev_data);
                end
            end
            vectors++;
            if ((req_ready & ~grant) !== '0 || $countones(grant) > 1) begin
                miscompares++;
                $display("FAIL grant_ready: got grant=%b ready=%b, expected one-hot grant covering ready",
                         grant, req_ready);
            end
            if (in_valid && in_ready) begin
                vectors++;
                if (in_data !== exp_q[0]) begin
                    miscompares++;
                    $display("FAIL stream: got %02h, expected %02h", in_data, exp_q[0]);
                end
                out_log.push_back(in_data);
                void'(exp_q.pop_front());
            end
            acc        = req_valid & req_ready;
            prev_stall = in_valid & ~in_ready;
            prev_data  = in_data;
            @(posedge clk); #1;
            for (int n = 0; n < NUM_REQ; n++) if (acc[n]) void'(rq[n].pop_front());
            cyc++;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL stream_timeout: got %0d bytes outstanding, expected 0", exp_q.size());
        end
        drive_reqs();
        in_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if (in_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL extra_output: got in_valid=%0b data=%02h, expected in_valid=0", in_valid, in_data);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; configured = 1'b0; req_valid = '0; req_last = '0; req_data = '0; in_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (grant !== 4'b0000 || req_ready !== 4'b0000 || in_valid !== 1'b0 || in_data !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_state: got grant=%b ready=%b valid=%0b data=%02h, expected all zero",
                     grant, req_ready, in_valid, in_data);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    task automatic test_idle();
        configured = 1'b1;
        in_ready   = 1'b1;
        repeat (20) begin
            @(negedge clk);
            vectors++;
            if (in_valid !== 1'b0 || grant !== 4'b0000) begin
                miscompares++;
                $display("FAIL idle: got valid=%0b grant=%b, expected 0 and 0000", in_valid, grant);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_single_burst();
        rq[0].push_back({1'b0, 8'h11});
        rq[0].push_back({1'b0, 8'h22});
        rq[0].push_back({1'b1, 8'h33});
        run_engine(0, 100);
        vectors++;
        if (log_grant.size() < 5 + HL || log_grant[0] !== 4'b0000 || log_grant[1] !== 4'b0001) begin
            miscompares++;
            $display("FAIL grant_latency: got %0d cycles logged, expected grant 0000 then 0001", log_grant.size());
        end
        vectors++;
        if (log_grant.size() >= 5 + HL &&
            (log_data[2+HL] !== 8'h11 || log_data[3+HL] !== 8'h22 || log_data[4+HL] !== 8'h33 ||
             !log_valid[2+HL] || !log_valid[3+HL] || !log_valid[4+HL])) begin
            miscompares++;
            $display("FAIL byte_timing: got %02h %02h %02h, expected 11 22 33 on consecutive clks",
                     log_data[2+HL], log_data[3+HL], log_data[4+HL]);
        end
        vectors++;
        if (log_grant.size() >= 5 + HL && log_grant[4+HL] !== 4'b0000) begin
            miscompares++;
            $display("FAIL burst_release: got grant=%b, expected 0000", log_grant[4+HL]);
        end
        if (TAG) begin
            vectors++;
            if (log_grant.size() >= 5 + HL && log_data[2] !== 8'hA0) begin
                miscompares++;
                $display("FAIL header_r0: got %02h, expected a0", log_data[2]);
            end
        end
    endtask

    task automatic test_round_robin();
        int first_v, last_v, gaps;
        for (int i = 0; i < 16; i++) rq[1].push_back({1'b0, 8'(8'h10 + i)});
        for (int i = 0; i < 8; i++)  rq[2].push_back({1'b0, 8'(8'h20 + i)});
        run_engine(0, 200);
        vectors++;
        if (out_log.size() != 24 + 3*HL) begin
            miscompares++;
            $display("FAIL rr_count: got %0d bytes, expected %0d", out_log.size(), 24 + 3*HL);
        end else begin
            vectors++;
            if (out_log[HL] !== 8'h10 || out_log[8+2*HL] !== 8'h20 || out_log[16+3*HL] !== 8'h18) begin
                miscompares++;
                $display("FAIL rr_order: got %02h %02h %02h, expected 10 20 18",
                         out_log[HL], out_log[8+2*HL], out_log[16+3*HL]);
            end
        end
        first_v = -1; last_v = -1; gaps = 0;
        for (int i = 0; i < log_valid.size(); i++) if (log_valid[i]) begin
            if (first_v < 0) first_v = i;
            last_v = i;
        end
        for (int i = first_v; i <= last_v && first_v >= 0; i++) if (!log_valid[i]) gaps++;
        vectors++;
        if (gaps != 2) begin
            miscompares++;
            $display("FAIL rr_bubbles: got %0d idle clks, expected 2", gaps);
        end
    endtask

    task automatic test_ready_toggle();
        for (int i = 0; i < 6; i++) rq[0].push_back({(i == 5) ? 1'b1 : 1'b0, 8'($urandom)});
        for (int i = 0; i < 5; i++) rq[3].push_back({(i == 4) ? 1'b1 : 1'b0, 8'($urandom)});
        run_engine(1, 300);
    endtask

    task automatic test_config_drop();
        int acc_cnt;
        logic hit;
        for (int i = 0; i < 5; i++) rq[0].push_back({(i == 4) ? 1'b1 : 1'b0, 8'(8'h51 + i)});
        configured = 1'b1;
        in_ready   = 1'b1;
        acc_cnt    = 0;
        for (int c = 0; c < 40 && acc_cnt < 2; c++) begin
            drive_reqs();
            @(negedge clk);
            hit = req_valid[0] & req_ready[0];
            @(posedge clk); #1;
            if (hit) begin void'(rq[0].pop_front()); acc_cnt++; end
        end
        vectors++;
        if (acc_cnt != 2) begin
            miscompares++;
            $display("FAIL cfg_setup: got %0d bytes accepted, expected 2", acc_cnt);
        end
        configured = 1'b0;
        in_ready   = 1'b0;
        drive_reqs();
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0000) begin
            miscompares++;
            $display("FAIL cfg_ready: got %b, expected 0000", req_ready);
        end
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if (grant !== 4'b0000) begin
            miscompares++;
            $display("FAIL cfg_grant: got %b, expected 0000", grant);
        end
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if (in_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL cfg_drop_valid: got %0b, expected 0", in_valid);
        end
        @(posedge clk); #1;
        repeat (8) begin
            @(negedge clk);
            vectors++;
            if (grant !== 4'b0000 || in_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL cfg_hold: got grant=%b valid=%0b, expected 0000 and 0", grant, in_valid);
            end
            @(posedge clk); #1;
        end
        model_ptr  = 1;
        configured = 1'b1;
        run_engine(0, 100);
    endtask

    task automatic test_random();
        int len;
        repeat (3) begin
            for (int n = 0; n < NUM_REQ; n++) begin
                len = $urandom_range(0, 20);
                for (int i = 0; i < len; i++)
                    rq[n].push_back({(i == len - 1) || ($urandom_range(0, 3) == 0), 8'($urandom)});
            end
            run_engine(2, 2000);
        end
    endtask

    task automatic test_reset_mid_burst();
        for (int i = 0; i < 6; i++) rq[2].push_back({1'b0, 8'(8'hC0 + i)});
        configured = 1'b1;
        in_ready   = 1'b0;
        drive_reqs();
        repeat (4) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        vectors++;
        if (grant !== 4'b0000 || in_valid !== 1'b0 || in_data !== 8'h00 || req_ready !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_mid_burst: got grant=%b valid=%0b data=%02h, expected 0000 0 00",
                     grant, in_valid, in_data);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        rq[2].delete();
        drive_reqs();
        model_ptr = 0;
    endtask

    task automatic test_single_tagged();
        rq[3].push_back({1'b1, 8'h5A});
        run_engine(0, 100);
        vectors++;
        if (out_log.size() != 1 + HL || out_log[0] !== (TAG ? 8'hA3 : 8'h5A)) begin
            miscompares++;
            $display("FAIL single_req3: got %0d bytes first=%02h, expected %0d bytes first=%02h",
                     out_log.size(), (out_log.size() > 0) ? out_log[0] : 8'h00, 1 + HL, TAG ? 8'hA3 : 8'h5A);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single_burst();
        test_round_robin();
        test_ready_toggle();
        test_config_drop();
        test_random();
        test_reset_mid_burst();
        test_single_tagged();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
